// File: rtl/lagd_island_ctrl.sv
// rtl/lagd_island_ctrl.sv - island job sequencer: block load, anneal iterations, timeout and status
module lagd_island_ctrl #(
    parameter int unsigned NumMemBlocks = 4,
    parameter int unsigned CntWidth     = 32,
    localparam int unsigned BlkW = (NumMemBlocks > 1) ? $clog2(NumMemBlocks) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    clear_i,
    input  logic [NumMemBlocks-1:0] cfg_blk_mask_i,
    input  logic [CntWidth-1:0]     cfg_num_iter_i,
    input  logic [CntWidth-1:0]     cfg_timeout_i,
    output logic                    load_req_o,
    output logic [BlkW-1:0]         load_blk_o,
    input  logic                    load_ack_i,
    output logic                    core_start_o,
    input  logic                    core_done_i,
    output logic                    mem_sel_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_timeout_o,
    output logic                    irq_o,
    output logic [CntWidth-1:0]     iter_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WAIT,
        S_FINISH
    } state_e;

    state_e                  state_q, state_d;
    logic [NumMemBlocks-1:0] rem_q, rem_d;
    logic [CntWidth-1:0]     eff_iter_q, eff_iter_d;
    logic [CntWidth-1:0]     tmo_lim_q, tmo_lim_d;
    logic [CntWidth-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [CntWidth-1:0]     iter_q, iter_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [BlkW-1:0]         blk_idx;
    logic [CntWidth-1:0]     iter_inc;
    logic [CntWidth-1:0]     tmo_inc;

    // rem_q holds the blocks still to load; the lowest set bit is the one being served.
    always_comb begin
        blk_idx = '0;
        for (int i = NumMemBlocks - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
                blk_idx = BlkW'(i);
            end
        end
    end

    assign iter_inc = iter_q + CntWidth'(1);
    assign tmo_inc  = tmo_cnt_q + CntWidth'(1);

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        eff_iter_d = eff_iter_q;
        tmo_lim_d  = tmo_lim_q;
        tmo_cnt_d  = tmo_cnt_q;
        iter_d     = iter_q;
        done_d     = done_q & ~clear_i;
        err_d      = err_q & ~clear_i;

        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        rem_d      = cfg_blk_mask_i;
                        eff_iter_d = (cfg_num_iter_i == '0) ? CntWidth'(1) : cfg_num_iter_i;
                        tmo_lim_d  = cfg_timeout_i;
                        iter_d     = '0;
                        done_d     = 1'b0;
                        err_d      = 1'b0;
                        state_d    = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (rem_q == '0) begin
                        state_d = S_RUN;
                    end else if (load_ack_i) begin
                        rem_d = rem_q & (rem_q - NumMemBlocks'(1));
                        if (rem_d == '0) begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    tmo_cnt_d = '0;
                    state_d   = S_WAIT;
                end
                S_WAIT: begin
                    tmo_cnt_d = tmo_inc;
                    // A completion on the timeout cycle still counts as a good iteration.
                    if (core_done_i) begin
                        iter_d  = iter_inc;
                        state_d = (iter_inc == eff_iter_q) ? S_FINISH : S_RUN;
                    end else if ((tmo_lim_q != '0) && (tmo_inc == tmo_lim_q)) begin
                        err_d   = 1'b1;
                        state_d = S_FINISH;
                    end
                end
                S_FINISH: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            eff_iter_q <= '0;
            tmo_lim_q  <= '0;
            tmo_cnt_q  <= '0;
            iter_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            eff_iter_q <= eff_iter_d;
            tmo_lim_q  <= tmo_lim_d;
            tmo_cnt_q  <= tmo_cnt_d;
            iter_q     <= iter_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign load_req_o    = (state_q == S_LOAD) && (rem_q != '0);
    assign load_blk_o    = (state_q == S_LOAD) ? blk_idx : '0;
    assign core_start_o  = (state_q == S_RUN) && !abort_i;
    assign irq_o         = (state_q == S_FINISH) && !abort_i;
    assign mem_sel_o     = (state_q == S_RUN) || (state_q == S_WAIT);
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign err_timeout_o = err_q;
    assign iter_cnt_o    = iter_q;

endmodule

// File: doc/lagd_island_ctrl.md
LAGD_ISLAND_CTRL -- requirements
Module: lagd_island_ctrl

Interface
REQ-001 SHALL have parameter NumMemBlocks, default 4, number of Ising memory blocks per island.
REQ-002 SHALL have parameter CntWidth, default 32, width of the iteration and timeout counters.
REQ-003 SHALL have clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have start_i  in  1  single-cycle start pulse from the island register file.
REQ-006 SHALL have abort_i  in  1  abort current job.
REQ-007 SHALL have clear_i  in  1  clear sticky status.
REQ-008 SHALL have cfg_blk_mask_i  in  NumMemBlocks  blocks to load before the run.
REQ-009 SHALL have cfg_num_iter_i  in  CntWidth  anneal iterations; 0 is treated as 1.
REQ-010 SHALL have cfg_timeout_i  in  CntWidth  per-iteration cycle limit; 0 disables the limit.
REQ-011 SHALL have load_req_o  out  1, load_blk_o  out  $clog2(NumMemBlocks), and load_ack_i  in  1, forming the block-load handshake.
REQ-012 SHALL have core_start_o  out  1  one-cycle iteration start pulse, and core_done_i  in  1  iteration complete.
REQ-013 SHALL have mem_sel_o  out  1: 1 = Ising core owns the memory blocks, 0 = AXI side owns them.
REQ-014 SHALL have busy_o, done_o, err_timeout_o, and irq_o  out  1 each, plus iter_cnt_o  out  CntWidth.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN, WAIT, FINISH.
REQ-016 SHALL, in IDLE on start_i, latch all cfg_* inputs into shadow registers, clear iter_cnt_o, and go to LOAD. Config changes after start SHALL have no effect.
REQ-017 SHALL ignore start_i in every state other than IDLE.
REQ-018 SHALL, in LOAD, visit set bits of the latched mask in ascending index order: load_req_o=1 with load_blk_o = current index, held stable until load_ack_i is sampled high.
REQ-019 SHALL, on load_ack_i, advance to the next set bit in the following cycle, or go to RUN after the last one. Back-to-back acks SHALL therefore serve one block per cycle.
REQ-020 SHALL go from LOAD directly to RUN when the latched mask is all-zero, with load_req_o never asserted.
REQ-021 SHALL, in RUN, assert core_start_o for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-022 SHALL hold mem_sel_o=1 in RUN and WAIT, and 0 in all other states.
REQ-023 SHALL, in WAIT on core_done_i, increment iter_cnt_o. If the new value equals the effective iteration count, go to FINISH; otherwise go to RUN.
REQ-024 SHALL, in WAIT with latched timeout T≠0, count cycles from 1. When the count reaches T without core_done_i, set err_timeout_o and go to FINISH.
REQ-025 SHALL give core_done_i priority when it coincides with the timeout cycle: the iteration completes and no error is flagged.
REQ-026 SHALL ignore core_done_i outside WAIT and load_ack_i outside LOAD.
REQ-027 SHALL, in FINISH, pulse irq_o for exactly one cycle, set done_o, and return to IDLE.
REQ-028 SHALL, on abort_i in any non-IDLE state, go to IDLE next cycle with no irq_o and no done_o change; iter_cnt_o keeps its value. abort_i SHALL win over any simultaneous event.
REQ-029 SHALL keep done_o and err_timeout_o sticky until clear_i or the next accepted start_i. When clear_i and start_i coincide, both SHALL take effect.
REQ-030 SHALL drive busy_o=1 in every state except IDLE.
REQ-031 SHALL wrap iter_cnt_o modulo 2^CntWidth. No other saturation is required, since the count terminates at the effective iteration count.

Reset
REQ-032 SHALL, while rst_ni=0, force state IDLE and all outputs to 0, including iter_cnt_o, load_blk_o and the shadow registers, independent of clk_i.
REQ-033 SHALL abandon any in-progress job on reset mid-operation, without an irq_o pulse after reset release.

Verification
REQ-034 Mask=4'b0101, iter=2, timeout=0, ack one cycle after each req, done 5 cycles after each core_start_o -> load_blk_o 0 then 2; two core_start_o pulses; iter_cnt_o=2; one irq_o; done_o=1; err_timeout_o=0.
REQ-035 Mask=0, iter=0 -> no load_req_o; exactly one core_start_o; FINISH after the first core_done_i.
REQ-036 Timeout=10, core_done_i never asserted -> err_timeout_o rises on the 10th WAIT cycle; irq_o pulses; mem_sel_o returns to 0.
REQ-037 Timeout=10, core_done_i on exactly the 10th WAIT cycle -> no error; the iteration is counted.
REQ-038 abort_i during LOAD with load_req_o high -> IDLE next cycle; load_req_o=0; no irq_o; a subsequent start_i runs normally.
REQ-039 rst_ni asserted in WAIT, then start_i while busy, then clear_i+start_i together -> immediate reset to zeros; the busy start is ignored; the coincident pair clears status and starts a new job.
